log2_sched: RTL and testbench
=============================

# log2_sched

Round-robin scheduler that shares one pipelined log2 core (any of the lin/LUT/CORDIC variants, fixed latency, no backpressure) between several requesters. It accepts operands over per-requester valid/ready ports and issues at most one operand per cycle into the core. Each issued request is tagged with its requester ID, and results come back as a single in-order, ID-tagged output stream with valid/ready flow control. A credit counter guarantees that every in-flight result has a slot reserved, so the core never needs to be stalled.

## Interface
- REQUESTERS, 4, number of requester ports (2..16)
- INPUT_WIDTH, 18, operand width fed to the core
- OUTPUT_WIDTH, 18, signed log2 result width returned by the core
- RESULT_DEPTH, 16, result FIFO depth; equals the maximum outstanding plus buffered results (power of 2)
- IDW, $clog2(REQUESTERS), localparam, tag width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- req_data_i  in  REQUESTERS*INPUT_WIDTH  operands; requester k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH]
- req_valid_i  in  REQUESTERS  per-requester request valid
- req_ready_o  out  REQUESTERS  per-requester accept; one-hot or zero
- core_data_o  out  INPUT_WIDTH  operand to the core's data_i
- core_valid_o  out  1  to the core's valid_i
- core_log2_i  in  OUTPUT_WIDTH  from the core's log2_o
- core_valid_i  in  1  from the core's valid_o
- res_log2_o  out  OUTPUT_WIDTH  result
- res_id_o  out  IDW  requester that issued this result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- err_o  out  1  sticky protocol error (only with LOG2_SCHED_ERR_EN)

## Operation
- Credit counter `credits` (0..RESULT_DEPTH) resets to RESULT_DEPTH.
  - Decremented on every request handshake.
  - Incremented on every result handshake (res_valid_o && res_ready_i).
  - Both in the same cycle: credits unchanged.
- Grant (combinational):
  - When credits > 0, the first requester with req_valid_i set, searching from rr_ptr upward with wrap, gets req_ready_o = 1.
  - When credits == 0, all req_ready_o = 0.
  - req_ready_o may depend on req_valid_i. The grant uses the registered credits only; a result pop in the same cycle does not enable a grant until the next cycle.
- Handshake on requester k:
  - rr_ptr <= (k+1) mod REQUESTERS.
  - The operand is registered to core_data_o and core_valid_o = 1 next cycle.
  - k is pushed into the tag FIFO (depth RESULT_DEPTH).
- With no handshake: core_valid_o <= 0, core_data_o holds its value, rr_ptr holds.
- Core return (core_valid_i = 1):
  - Pop the tag FIFO.
  - Push {tag, core_log2_i} into the result FIFO.
  - The credit invariant guarantees the result FIFO is never full at this point.
- Result FIFO output:
  - First-word-fall-through, registered.
  - res_valid_o = !empty.
  - res_log2_o/res_id_o are stable while res_valid_o && !res_ready_i.
- Ordering: results leave in issue order. The core is in-order, so the tag FIFO order matches.
- Reset: every output goes to 0 at once, rr_ptr = 0, both FIFOs empty, credits = RESULT_DEPTH. Any in-flight core results arriving after reset are handled per Configuration.

## Timing
- Request handshake at edge N → core_valid_o high in cycle N+1.
- Core valid_o at edge M → res_valid_o high in cycle M+1, if the FIFO was empty.
- End-to-end: request-to-result = core latency + 2 cycles.
- Throughput: 1 request/cycle sustained while res_ready_i = 1 and RESULT_DEPTH ≥ core latency + 2.

## Configuration
- LOG2_SCHED_ERR_EN defined:
  - err_o exists.
  - err_o is set when core_valid_i = 1 while the tag FIFO is empty; it is sticky until reset.
  - The stray result is dropped: no result FIFO push, no credit change.
- LOG2_SCHED_ERR_EN undefined:
  - err_o port absent.
  - Stray results are silently dropped by the same guard.

## Test plan
Core = log2lin model with INPUT_POINT 16, OUTPUT_POINT 12, latency L.
- Requester 2 sends 0x20000 (2.0) at edge 0, res_ready_i = 1 → res_valid_o at cycle L+2, res_log2_o = 0x01000, res_id_o = 2; requester 1 sends 0x08000 → 0x3F000 (-4096).
- All 4 requesters hold valid, res_ready_i = 1 → grants 0,1,2,3,0,1… one per cycle, no gaps; result IDs follow the same sequence.
- res_ready_i = 0, all valid → exactly 16 handshakes, then req_ready_o = 0 permanently. Raise res_ready_i for one cycle → exactly one further grant, in the following cycle.
- Full state (credits 0), pop and request in the same cycle → no grant that cycle, a grant the next cycle; credits returns to 0.
- Assert reset with 5 requests in flight → all outputs 0 during reset, credits = 16 after release. With LOG2_SCHED_ERR_EN, the late core returns set err_o = 1 and produce no res_valid_o.
- With LOG2_SCHED_ERR_EN, inject core_valid_i with nothing outstanding → err_o = 1 next cycle and stays high, res_valid_o stays 0.

Source files
------------

// File: rtl/log2_sched.sv
// Round-robin scheduler sharing one fixed-latency log2 core between REQUESTERS ports.
// Optional sticky protocol-error output err_o is enabled by defining LOG2_SCHED_ERR_EN.
module log2_sched #(
    parameter int REQUESTERS   = 4,
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 18,
    parameter int RESULT_DEPTH = 16,
    localparam int IDW = $clog2(REQUESTERS)
) (
    input  logic                             clock,
    input  logic                             reset,
`ifdef LOG2_SCHED_ERR_EN
    output logic                             err_o,
`endif
    input  logic [REQUESTERS*INPUT_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]            req_valid_i,
    output logic [REQUESTERS-1:0]            req_ready_o,
    output logic [INPUT_WIDTH-1:0]           core_data_o,
    output logic                             core_valid_o,
    input  logic [OUTPUT_WIDTH-1:0]          core_log2_i,
    input  logic                             core_valid_i,
    output logic [OUTPUT_WIDTH-1:0]          res_log2_o,
    output logic [IDW-1:0]                   res_id_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i
);
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam int CW = $clog2(RESULT_DEPTH + 1);
    localparam int RW = IDW + OUTPUT_WIDTH;
    localparam logic [IDW:0] NREQ = (IDW + 1)'(REQUESTERS);

    logic [CW-1:0]         credits;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_id;
    logic [IDW-1:0]        next_ptr;
    logic [IDW:0]          cand;
    logic [REQUESTERS-1:0] grant;
    logic                  grant_found;
    logic                  req_fire;
    logic                  res_fire;

    logic [IDW-1:0]        tag_mem [RESULT_DEPTH];
    logic [AW-1:0]         tag_wr;
    logic [AW-1:0]         tag_rd;
    logic [AW:0]           tag_cnt;
    logic                  tag_pop;

    logic [RW-1:0]         res_mem [RESULT_DEPTH];
    logic [AW-1:0]         res_wr;
    logic [AW-1:0]         res_rd;
    logic [AW:0]           res_cnt;
    logic [RW-1:0]         res_in;
    logic [RW-1:0]         out_data;
    logic                  out_load;
    logic                  bypass;
    logic                  res_wr_en;
    logic                  res_rd_en;

    // Round-robin search from rr_ptr upward with wrap; gated by registered credits only
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int j = 0; j < REQUESTERS; j++) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(j);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end else begin
                cand = cand;
            end
            if (!grant_found && (credits != '0) && req_valid_i[cand[IDW-1:0]]) begin
                grant[cand[IDW-1:0]] = 1'b1;
                grant_id             = cand[IDW-1:0];
                grant_found          = 1'b1;
            end else begin
                grant_found = grant_found;
            end
        end
    end

    // Ready is forced low while reset is asserted
    always_comb begin
        if (reset) begin
            req_ready_o = '0;
        end else begin
            req_ready_o = grant;
        end
    end

    assign req_fire = |req_ready_o;
    assign next_ptr = (grant_id == IDW'(REQUESTERS - 1)) ? '0 : grant_id + IDW'(1);
    assign res_fire = res_valid_o && res_ready_i;

    // Issue register towards the core and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_valid_o <= 1'b0;
            core_data_o  <= '0;
            rr_ptr       <= '0;
        end else begin
            core_valid_o <= req_fire;
            if (req_fire) begin
                core_data_o <= req_data_i[grant_id*INPUT_WIDTH +: INPUT_WIDTH];
                rr_ptr      <= next_ptr;
            end
        end
    end

    // Credit counter: one slot reserved per outstanding or buffered result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits <= CW'(RESULT_DEPTH);
        end else begin
            case ({req_fire, res_fire})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // A core return with no outstanding tag is stray and gets dropped here
    assign tag_pop = core_valid_i && (tag_cnt != '0);

    // Tag storage
    always_ff @(posedge clock) begin
        if (req_fire) begin
            tag_mem[tag_wr] <= grant_id;
        end
    end

    // Tag FIFO pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (req_fire) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (tag_pop) begin
                tag_rd <= tag_rd + AW'(1);
            end
            case ({req_fire, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + (AW + 1)'(1);
                2'b01:   tag_cnt <= tag_cnt - (AW + 1)'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Results go straight to the output register when the buffer is empty and the slot is free
    assign res_in    = {tag_mem[tag_rd], core_log2_i};
    assign out_load  = !res_valid_o || res_ready_i;
    assign bypass    = out_load && (res_cnt == '0);
    assign res_wr_en = tag_pop && !bypass;
    assign res_rd_en = out_load && (res_cnt != '0);

    // Result storage
    always_ff @(posedge clock) begin
        if (res_wr_en) begin
            res_mem[res_wr] <= res_in;
        end
    end

    // Result FIFO pointers and registered output stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_wr      <= '0;
            res_rd      <= '0;
            res_cnt     <= '0;
            res_valid_o <= 1'b0;
            out_data    <= '0;
        end else begin
            if (res_wr_en) begin
                res_wr <= res_wr + AW'(1);
            end
            if (res_rd_en) begin
                res_rd      <= res_rd + AW'(1);
                out_data    <= res_mem[res_rd];
                res_valid_o <= 1'b1;
            end else if (out_load) begin
                if (tag_pop) begin
                    out_data    <= res_in;
                    res_valid_o <= 1'b1;
                end else begin
                    res_valid_o <= 1'b0;
                end
            end
            case ({res_wr_en, res_rd_en})
                2'b10:   res_cnt <= res_cnt + (AW + 1)'(1);
                2'b01:   res_cnt <= res_cnt - (AW + 1)'(1);
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    assign {res_id_o, res_log2_o} = out_data;

`ifdef LOG2_SCHED_ERR_EN
    logic stray;
    assign stray = core_valid_i && (tag_cnt == '0);

    // Sticky error on a core return with nothing outstanding
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (stray) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_log2_sched.sv
// Self-checking bench for log2_sched with a linear-interpolation log2 core model (latency L).
module tb_log2_sched;
    localparam int R   = 4;
    localparam int IW  = 18;
    localparam int OW  = 18;
    localparam int D   = 16;
    localparam int IDW = 2;
    localparam int L   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [R*IW-1:0]   req_data = '0;
    logic [R-1:0]      req_valid = '0;
    logic [R-1:0]      req_ready;
    logic [IW-1:0]     core_data;
    logic              core_valid;
    logic [OW-1:0]     core_log2;
    logic              core_ret;
    logic [OW-1:0]     res_log2;
    logic [IDW-1:0]    res_id;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              inject = 1'b0;
`ifdef LOG2_SCHED_ERR_EN
    logic              err;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [IDW+OW-1:0] sb[$];
    int m_credits = D;
    int m_rr      = 0;

    logic [L-1:0]  pipe_v = '0;
    logic [OW-1:0] pipe_d [L];

    always #5 clock = ~clock;

    log2_sched #(.REQUESTERS(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .RESULT_DEPTH(D)) dut (
        .clock(clock),
        .reset(reset),
`ifdef LOG2_SCHED_ERR_EN
        .err_o(err),
`endif
        .req_data_i(req_data),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .core_data_o(core_data),
        .core_valid_o(core_valid),
        .core_log2_i(core_log2),
        .core_valid_i(core_ret),
        .res_log2_o(res_log2),
        .res_id_o(res_id),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready)
    );

    // log2 of an unsigned Q2.16 operand, Q.12 output, linear between powers of two
    function automatic logic [OW-1:0] log2lin(input logic [IW-1:0] x);
        int p;
        int frac;
        int r;
        p = 0;
        for (int i = 0; i < IW; i++) if (x[i]) p = i;
        if (p >= 12) frac = (int'(x) - (1 << p)) >>> (p - 12);
        else         frac = (int'(x) - (1 << p)) <<< (12 - p);
        r = ((p - 16) <<< 12) + frac;
        return OW'(r);
    endfunction

    // Core model: fixed latency, not reset, so in-flight results survive a scheduler reset
    always @(posedge clock) begin
        pipe_v    <= {pipe_v[L-2:0], core_valid};
        pipe_d[0] <= log2lin(core_data);
        for (int i = 1; i < L; i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign core_ret  = pipe_v[L-1] | inject;
    assign core_log2 = pipe_d[L-1];

    // Arbiter/credit model and result scoreboard
    initial begin : monitor
        logic [R-1:0] exp;
        int gi;
        int idx;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_credits = D;
                m_rr      = 0;
                sb.delete();
            end else begin
                exp = '0;
                gi  = -1;
                if (m_credits > 0) begin
                    for (int i = 0; i < R; i++) begin
                        idx = (m_rr + i) % R;
                        if (gi < 0 && req_valid[idx]) begin
                            gi       = idx;
                            exp[idx] = 1'b1;
                        end
                    end
                end
                compared++;
                if (req_ready !== exp) begin
                    mismatched++;
                    $display("FAIL grant: req_ready_o=%b required %b at %0t", req_ready, exp, $time);
                end
                if (res_valid) begin
                    compared++;
                    if (sb.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_result: id=%0d log2=%h with nothing expected at %0t", res_id, res_log2, $time);
                    end else begin
                        if ({res_id, res_log2} !== sb[0]) begin
                            mismatched++;
                            $display("FAIL result: got id=%0d log2=%h required id=%0d log2=%h at %0t",
                                     res_id, res_log2, sb[0][IDW+OW-1:OW], sb[0][OW-1:0], $time);
                        end
                        if (res_ready) begin
                            void'(sb.pop_front());
                            m_credits++;
                        end
                    end
                end
                if (gi >= 0) begin
                    sb.push_back({IDW'(gi), log2lin(req_data[gi*IW +: IW])});
                    m_rr = (gi + 1) % R;
                    m_credits--;
                end
            end
        end
    end

    task automatic randomize_data;
        for (int k = 0; k < R; k++) req_data[k*IW +: IW] = IW'($urandom_range(1, 262143));
    endtask

    task automatic pulse_reset;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        compared++;
        if ({req_ready, core_valid, core_data, res_valid, res_log2, res_id} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h required 0", {req_ready, core_valid, core_data, res_valid, res_log2, res_id});
        end
`ifdef LOG2_SCHED_ERR_EN
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_err: got %b required 0", err);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        compared++;
        if (res_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_valid: got %b required 0", res_valid);
        end
    endtask

    task automatic test_single(input int k, input logic [IW-1:0] x, input logic [OW-1:0] want);
        int n;
        @(posedge clock); #1;
        req_data[k*IW +: IW] = x;
        req_valid            = '0;
        req_valid[k]         = 1'b1;
        res_ready            = 1'b1;
        @(negedge clock);
        compared++;
        if (req_ready !== req_valid) begin
            mismatched++;
            $display("FAIL single_grant: got %b required %b", req_ready, req_valid);
        end
        @(posedge clock); #1;
        req_valid = '0;
        n = 1;
        @(negedge clock);
        while (!res_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (n != L + 2) begin
            mismatched++;
            $display("FAIL single_latency: got %0d cycles required %0d", n, L + 2);
        end
        compared++;
        if (res_log2 !== want) begin
            mismatched++;
            $display("FAIL single_value: got %h required %h", res_log2, want);
        end
        compared++;
        if (res_id !== IDW'(k)) begin
            mismatched++;
            $display("FAIL single_id: got %0d required %0d", res_id, k);
        end
    endtask

    task automatic test_round_robin;
        logic [R-1:0] one;
        one = 4'b0001;
        pulse_reset();
        @(posedge clock); #1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            randomize_data();
            @(negedge clock);
            compared++;
            if (req_ready !== (one << (i % R))) begin
                mismatched++;
                $display("FAIL rr_sequence: step %0d got %b required %b", i, req_ready, one << (i % R));
            end
            @(posedge clock); #1;
        end
        req_valid = '0;
    endtask

    task automatic drain;
        int c;
        req_valid = '0;
        c = 0;
        while (c < 400 && !(sb.size() == 0 && !res_valid)) begin
            @(posedge clock); #1;
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            c++;
        end
        compared++;
        if (sb.size() != 0 || res_valid) begin
            mismatched++;
            $display("FAIL drain: %0d results still expected after %0d cycles", sb.size(), c);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
    endtask

    task automatic test_stray;
        @(negedge clock);
`ifdef LOG2_SCHED_ERR_EN
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL stray_err_before: got %b required 0", err);
        end
`endif
        @(posedge clock); #1;
        inject = 1'b1;
        @(posedge clock); #1;
        inject = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
`ifdef LOG2_SCHED_ERR_EN
            compared++;
            if (err !== 1'b1) begin
                mismatched++;
                $display("FAIL stray_err: cycle %0d got %b required 1", c, err);
            end
`endif
            compared++;
            if (res_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL stray_res_valid: cycle %0d got %b required 0", c, res_valid);
            end
        end
    endtask

    task automatic test_reset_inflight;
        @(posedge clock); #1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            randomize_data();
            @(negedge clock);
            @(posedge clock); #1;
        end
        req_valid = '0;
        reset     = 1'b1;
        #1;
        compared++;
        if ({req_ready, core_valid, core_data, res_valid, res_log2, res_id} !== '0) begin
            mismatched++;
            $display("FAIL inflight_reset_outputs: got %h required 0", {req_ready, core_valid, core_data, res_valid, res_log2, res_id});
        end
`ifdef LOG2_SCHED_ERR_EN
        compared++;
        if (err !== 1'b0) begin
            mismatched++;
            $display("FAIL inflight_reset_err: got %b required 0", err);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            compared++;
            if (res_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL inflight_res_valid: cycle %0d got %b required 0", c, res_valid);
            end
        end
`ifdef LOG2_SCHED_ERR_EN
        compared++;
        if (err !== 1'b1) begin
            mismatched++;
            $display("FAIL inflight_err: got %b required 1", err);
        end
`endif
    endtask

    task automatic test_credit_limit;
        int n;
        n = 0;
        @(posedge clock); #1;
        req_valid = '1;
        res_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            randomize_data();
            @(negedge clock);
            if ((req_ready & req_valid) != '0) n++;
            @(posedge clock); #1;
        end
        compared++;
        if (n != D) begin
            mismatched++;
            $display("FAIL credit_handshakes: got %0d required %0d", n, D);
        end
        @(negedge clock);
        compared++;
        if (req_ready !== '0) begin
            mismatched++;
            $display("FAIL credit_stall: got %b required 0", req_ready);
        end
        @(posedge clock); #1;
        res_ready = 1'b1;
        @(negedge clock);
        compared++;
        if (req_ready !== '0) begin
            mismatched++;
            $display("FAIL pop_same_cycle: got %b required 0", req_ready);
        end
        @(posedge clock); #1;
        res_ready = 1'b0;
        @(negedge clock);
        compared++;
        if ($countones(req_ready) != 1) begin
            mismatched++;
            $display("FAIL pop_next_grant: got %b required one-hot", req_ready);
        end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            @(negedge clock);
            if (req_ready != '0) n++;
        end
        compared++;
        if (n != 0) begin
            mismatched++;
            $display("FAIL credit_refill: got %0d further grants required 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_single(2, 18'h20000, 18'h01000);
        test_single(1, 18'h08000, 18'h3F000);
        test_round_robin();
        drain();
        test_stray();
        test_reset_inflight();
        test_credit_limit();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared=%0d", compared);
        $fatal(1, "timeout");
    end

endmodule
